// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states and constants for the UART receive controller
package uart_rx_pkg;
    typedef enum logic [1:0] {IDLE, START_CHK, RECV, CHECK} rx_state_t;
    localparam int RX_BITS = 9;
    localparam int DEFAULT_CLKS_PER_BIT = 10;
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-period down-counter with one-cycle expire and saturating bit count
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    input  logic          cnt_en,
    output logic          expire,
    output logic [3:0]    bit_cnt
);
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0] bit_q, bit_d;
    assign expire = en && tmr_q == '0;
    assign bit_cnt = bit_q;
    always_comb begin
        tmr_d = load ? load_val : expire ? TW'(CLKS_PER_BIT - 1) : en ? tmr_q - 1'b1 : tmr_q;
        bit_d = load ? 4'd0 : (expire && cnt_en && bit_q != 4'(RX_BITS)) ? bit_q + 1'b1 : bit_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
            bit_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            bit_q <= bit_d;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start detect, mid-bit strobes, stop check and host byte buffer
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic [7:0] packet_data,
    input  logic       stop_bit,
    input  logic       data_read,
    output logic       shift_strobe,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    rx_state_t state_q, state_d;
    logic sync1_q, sync2_q, prev_q;
    logic [7:0] rx_data_q, rx_data_d;
    logic data_ready_q, data_ready_d, framing_q, framing_d, overrun_q, overrun_d;
    logic start_edge, expire, load_byte, accept;
    logic [3:0] bit_cnt;
    assign start_edge = prev_q && !sync2_q;
    assign accept = state_q == START_CHK && expire && !sync2_q;
    assign load_byte = state_q == CHECK && stop_bit;
    assign shift_strobe = state_q == RECV && expire;
    assign rx_data = rx_data_q;
    assign data_ready = data_ready_q;
    assign framing_error = framing_q;
    assign overrun_error = overrun_q;
    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q == IDLE && start_edge),
        .load_val(TW'(CLKS_PER_BIT / 2 - 1)),
        .en      (state_q == START_CHK || state_q == RECV),
        .cnt_en  (state_q == RECV),
        .expire  (expire),
        .bit_cnt (bit_cnt)
    );
    always_comb begin
        state_d = state_q == IDLE      ? (start_edge ? START_CHK : IDLE) :
                  state_q == START_CHK ? (expire ? (sync2_q ? IDLE : RECV) : START_CHK) :
                  state_q == RECV      ? ((expire && bit_cnt == 4'(RX_BITS - 1)) ? CHECK : RECV) :
                                         IDLE;
        rx_data_d = load_byte ? packet_data : rx_data_q;
        data_ready_d = load_byte || (data_ready_q && !data_read);
        overrun_d = load_byte ? (data_ready_q && !data_read) : (overrun_q && !data_read);
        framing_d = (state_q == CHECK && !stop_bit) || (framing_q && !accept);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q <= 1'b1;
            rx_data_q <= '0;
            data_ready_q <= 1'b0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q <= sync2_q;
            rx_data_q <= rx_data_d;
            data_ready_q <= data_ready_d;
            framing_q <= framing_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench pairing the controller with a 9-bit receive shift register
module tb_uart_rx_ctrl;
    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       fe;
        logic       ov;
        int         fall;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1, data_read = 1'b0;
    logic [8:0] sr = '0;
    logic shift_strobe, data_ready, framing_error, overrun_error;
    logic [7:0] rx_data;
    int cyc = 0, checks = 0, errors = 0, total_stb = 0, stb_before = 0;
    exp_t exp_q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};
    uart_rx_ctrl #(.CLKS_PER_BIT(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .packet_data  (sr[7:0]),
        .stop_bit     (sr[8]),
        .data_read    (data_read),
        .shift_strobe (shift_strobe),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check_outs(input string tag, input logic [7:0] d, input logic r, f, o);
        chk({tag, "_rx_data"}, rx_data, d);
        chk({tag, "_ready"}, data_ready, r);
        chk({tag, "_framing"}, framing_error, f);
        chk({tag, "_overrun"}, overrun_error, o);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit push,
                              input logic [7:0] ed, input logic er, ef, eo,
                              input int rd_at = -1, input int rst_at = -1, input bit fe_chk = 1'b0);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        if (push) exp_q.push_back('{ed, er, ef, eo, cyc});
        for (int i = 0; i < 100; i++) begin
            serial_in = fr[i / 10];
            data_read = (i == rd_at);
            rst = (i == rst_at);
            if (fe_chk && i == 7) chk("fe_held_in_start_chk", framing_error, 1);
            if (fe_chk && i == 8) chk("fe_cleared_at_recv", framing_error, 0);
            tick(1);
        end
        serial_in = 1'b1;
        data_read = 1'b0;
        rst = 1'b0;
        tick(5);
    endtask
    task automatic pulse_read();
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
    endtask
    initial begin
        int nstb = 0, first = 0, last = 0, chk_at = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                nstb = 0;
                chk_at = -1;
            end else begin
                if (shift_strobe) begin
                    if (nstb == 0) first = cyc;
                    else chk("strobe_spacing", cyc - last, 10);
                    last = cyc;
                    nstb++;
                    total_stb++;
                    if (nstb == 9) begin
                        chk_at = cyc + 2;
                        nstb = 0;
                    end
                end
                if (cyc == chk_at) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got rx_data %0h with no expectation", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("first_strobe_offset", first - e.fall, 17);
                        check_outs("frame", e.data, e.rdy, e.fe, e.ov);
                    end
                end
            end
        end
    end
    initial begin
        tick(2);
        rst = 1'b0;
        tick(20);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_outs("reset", 8'h00, 0, 0, 0);
        chk("reset_strobe", shift_strobe, 0);
        tick(20);
        chk("idle_no_strobes", total_stb, 0);
        send_frame(8'hA5, 1'b1, 1, 8'hA5, 1, 0, 0);
        pulse_read();
        chk("read_clears_ready", data_ready, 0);
        send_frame(8'h3C, 1'b0, 1, 8'hA5, 0, 1, 0);
        send_frame(8'h01, 1'b1, 1, 8'h01, 1, 0, 0, -1, -1, 1'b1);
        pulse_read();
        send_frame(8'h11, 1'b1, 1, 8'h11, 1, 0, 0);
        send_frame(8'h22, 1'b1, 1, 8'h22, 1, 0, 1);
        pulse_read();
        chk("read_clears_ready_ov", data_ready, 0);
        chk("read_clears_overrun", overrun_error, 0);
        stb_before = total_stb;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(40);
        chk("glitch_no_strobes", total_stb - stb_before, 0);
        check_outs("glitch", 8'h22, 0, 0, 0);
        send_frame(8'h33, 1'b1, 1, 8'h33, 1, 0, 0);
        send_frame(8'h77, 1'b1, 1, 8'h77, 1, 0, 0, 98);
        stb_before = total_stb;
        send_frame(8'hFF, 1'b1, 0, 8'h00, 0, 0, 0, -1, 52);
        chk("rst_mid_frame_strobes", total_stb - stb_before, 4);
        check_outs("rst_mid_frame", 8'h00, 0, 0, 0);
        send_frame(8'h5A, 1'b1, 1, 8'h5A, 1, 0, 0);
        tick(20);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
